// File: rtl/memo_rom_if.sv
// memo_rom_if: read bus between the program counter (master) and the instruction ROM (slave).
interface memo_rom_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] douta;
  modport master (output addra, input douta);
  modport slave  (input addra, output douta);
endinterface

// File: rtl/memo_rom.sv
// memo_rom: 32x8 instruction ROM with registered output for the 4-bit accumulator processor.
// Define DOUT_REG_EN to add a second output register (read latency 2).
module memo_rom #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic        clka,
  input  logic        rsta_n,
  memo_rom_if.slave   bus
);
  logic [DATA_W-1:0] w_rom;
  logic [DATA_W-1:0] r_dout;
  // Words above 14 stay NOP so a runaway fetch is harmless.
  always_comb begin
    w_rom = '0;
    case (bus.addra)
      5'd0:    w_rom = 8'h13;
      5'd1:    w_rom = 8'h22;
      5'd2:    w_rom = 8'h21;
      5'd3:    w_rom = 8'h41;
      5'd4:    w_rom = 8'h80;
      5'd5:    w_rom = 8'h15;
      5'd6:    w_rom = 8'h46;
      5'd7:    w_rom = 8'h80;
      5'd8:    w_rom = 8'h17;
      5'd9:    w_rom = 8'h27;
      5'd10:   w_rom = 8'h23;
      5'd11:   w_rom = 8'h43;
      5'd12:   w_rom = 8'h12;
      default: w_rom = 8'h00;
    endcase
  end
`ifdef DOUT_REG_EN
  logic [DATA_W-1:0] r_stage1;
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_stage1 <= '0;
      r_dout   <= '0;
    end else begin
      r_stage1 <= w_rom;
      r_dout   <= r_stage1;
    end
  end
`else
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) r_dout <= '0;
    else         r_dout <= w_rom;
  end
`endif
  assign bus.douta = r_dout;
endmodule

// File: tb/tb_memo_rom.sv
// tb_memo_rom: table vectors, hand-written reset/hold sequences and random reads against a ROM model.
module tb_memo_rom;
`ifdef DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clka = 1'b0;
  logic rsta_n = 1'b0;
  memo_rom_if #(.ADDR_W(5), .DATA_W(8)) bus ();
  memo_rom #(.ADDR_W(5), .DATA_W(8)) dut (.clka(clka), .rsta_n(rsta_n), .bus(bus));
  always #5 clka = ~clka;
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } vec_t;
  vec_t vt[$];
  logic [7:0] rom_m [32];
  logic [4:0] hist[$];
  int edges = 0;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [7:0] exp);
    n_cmp++;
    if (bus.douta !== exp) begin
      n_bad++;
      $display("FAIL %s: douta=%h expected=%h at %0t", name, bus.douta, exp, $time);
    end
  endtask
  // Drive an address at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic [4:0] a);
    bus.addra = a;
    @(posedge clka);
    if (rsta_n) begin
      hist.push_front(a);
      edges++;
      if (hist.size() > 8) void'(hist.pop_back());
    end
    @(negedge clka);
  endtask
  function automatic logic [7:0] model();
    return (edges < LAT) ? 8'h00 : rom_m[hist[LAT-1]];
  endfunction
  function automatic void add(input logic [4:0] a, input logic [7:0] d);
    vec_t v;
    v.a = a;
    v.d = d;
    vt.push_back(v);
  endfunction
  initial begin
    logic [7:0] sweep [15];
    sweep = '{8'h13, 8'h22, 8'h21, 8'h41, 8'h80, 8'h15, 8'h46, 8'h80,
              8'h17, 8'h27, 8'h23, 8'h43, 8'h12, 8'h00, 8'h00};
    for (int i = 0; i < 32; i++) rom_m[i] = (i < 15) ? sweep[i] : 8'h00;
    for (int i = 0; i < 15; i++) add(5'(i), sweep[i]);
    for (int i = 15; i < 32; i++) add(5'(i), 8'h00);
    add(5'd0, 8'h13);
    add(5'd9, 8'h27);
    add(5'd3, 8'h41);
    add(5'd9, 8'h27);
    add(5'd12, 8'h12);
    bus.addra = 5'd0;
    repeat (3) begin
      @(negedge clka);
      chk("reset_hold", 8'h00);
    end
    rsta_n = 1'b1;
    tick(5'd0);
    chk("rel_first", (LAT == 2) ? 8'h00 : 8'h13);
    tick(5'd1);
    chk("rel_second", (LAT == 2) ? 8'h13 : 8'h22);
    tick(5'd2);
    chk("rel_third", (LAT == 2) ? 8'h22 : 8'h21);
    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].a);
      if (i >= LAT - 1) chk($sformatf("vec%0d_addr%0d", i, vt[i-LAT+1].a), vt[i-LAT+1].d);
    end
    repeat (LAT - 1) tick(5'd5);
    for (int k = 0; k < 4; k++) begin
      tick(5'd5);
      chk("hold5_edge", 8'h15);
      #3 chk("hold5_mid", 8'h15);
    end
    @(negedge clka);
    repeat (LAT) tick(5'd9);
    chk("pre_rst_addr9", 8'h27);
    #2 rsta_n = 1'b0;
    #1 chk("async_rst", 8'h00);
    hist.delete();
    edges = 0;
    @(negedge clka);
    chk("rst_low_edge", 8'h00);
    tick(5'd4);
    chk("rst_low_tick", 8'h00);
    rsta_n = 1'b1;
    tick(5'd9);
    chk("post_rst_first", (LAT == 2) ? 8'h00 : 8'h27);
    tick(5'd10);
    chk("post_rst_second", (LAT == 2) ? 8'h27 : 8'h23);
    repeat (300) begin
      tick(5'($urandom_range(0, 31)));
      chk("rand", model());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
